// File: rtl/branch_target_adder_if.sv
// Control-transfer target bus between the decode/PC-select logic and the
// branch target adder. Inputs come from the master; results go back to it.
interface branch_target_adder_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm_gn;
    logic [XLEN-1:0] rs1;
    logic            is_jalr;
    logic            in_valid;

    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] pc_plus4;
    logic            misaligned;
    logic            wrap;

    logic [XLEN-1:0] target_q;
    logic            misaligned_q;
    logic            wrap_q;
    logic            out_valid;

    modport master (
        output pc, imm_gn, rs1, is_jalr, in_valid,
        input  branch_target, pc_plus4, misaligned, wrap,
        input  target_q, misaligned_q, wrap_q, out_valid
    );

    modport slave (
        input  pc, imm_gn, rs1, is_jalr, in_valid,
        output branch_target, pc_plus4, misaligned, wrap,
        output target_q, misaligned_q, wrap_q, out_valid
    );
endinterface

// File: rtl/branch_target_adder.sv
// RISC-V branch/JAL/JALR target adder with pc+4, misalignment and wrap
// flags, plus a one-cycle registered copy qualified by in_valid.
module branch_target_adder #(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_target_adder_if.slave  bus
);
    logic [XLEN-1:0] base;
    logic [XLEN:0]   sum_ext;
    logic            carry;
    logic [XLEN-1:0] target;
    logic            misaligned_c;
    logic            wrap_c;

    always_comb begin
        base = bus.is_jalr ? bus.rs1 : bus.pc;
        sum_ext = {1'b0, base} + {1'b0, bus.imm_gn};
        carry = sum_ext[XLEN];

        target = sum_ext[XLEN-1:0];
        if (bus.is_jalr) begin
            target[0] = 1'b0;
        end

        // A carry is expected when adding a negative immediate; only the
        // mismatch between carry and immediate sign means the address wrapped.
        wrap_c = carry ^ bus.imm_gn[XLEN-1];

        if (IALIGN == 16) begin
            misaligned_c = target[0];
        end else begin
            misaligned_c = |target[1:0];
        end
    end

    assign bus.branch_target = target;
    assign bus.misaligned    = misaligned_c;
    assign bus.wrap          = wrap_c;
    assign bus.pc_plus4      = bus.pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.target_q     <= '0;
            bus.misaligned_q <= 1'b0;
            bus.wrap_q       <= 1'b0;
            bus.out_valid    <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.target_q     <= target;
                bus.misaligned_q <= misaligned_c;
                bus.wrap_q       <= wrap_c;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_adder.sv
// Self-checking bench: directed vector table, randomized model comparison
// and hand-written registered-path / reset sequences, IALIGN 32 and 16.
module tb_branch_target_adder;
    logic clk;
    logic rst_n;

    int unsigned n_total;
    int unsigned n_pass;

    branch_target_adder_if #(.XLEN(32)) if32 ();
    branch_target_adder_if #(.XLEN(32)) if16 ();

    branch_target_adder #(.XLEN(32), .IALIGN(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32)
    );

    branch_target_adder #(.XLEN(32), .IALIGN(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        jalr;
        logic [31:0] exp_target;
        logic        exp_mis32;
        logic        exp_mis16;
        logic        exp_wrap;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vecs [9];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] im, input logic [31:0] r,
                         input logic j, input logic v);
        if32.pc = p;  if32.imm_gn = im;  if32.rs1 = r;  if32.is_jalr = j;  if32.in_valid = v;
        if16.pc = p;  if16.imm_gn = im;  if16.rs1 = r;  if16.is_jalr = j;  if16.in_valid = v;
    endtask

    // Reference: exact integer arithmetic, then reduce to the address space.
    function automatic void model(input logic [31:0] p, input logic [31:0] im, input logic [31:0] r,
                                  input logic j, output logic [31:0] t, output logic m32,
                                  output logic m16, output logic w, output logic [31:0] p4);
        longint base;
        longint s;
        longint u;
        base = j ? longint'({32'b0, r}) : longint'({32'b0, p});
        s = base + longint'($signed(im));
        u = s & 64'hFFFF_FFFF;
        t = u[31:0];
        if (j) t = t & ~32'd1;
        w = (s < 0) || (s >= 64'h1_0000_0000);
        m32 = (t % 4) != 0;
        m16 = (t % 2) != 0;
        u = (longint'({32'b0, p}) + 4) & 64'hFFFF_FFFF;
        p4 = u[31:0];
    endfunction

    initial begin
        logic [31:0] et, ep4;
        logic em32, em16, ew;
        logic [31:0] hq32, hq16;
        logic hm32, hm16, hw, hv;
        logic [31:0] rp, ri, rr;
        logic rj, rv;

        n_total = 0;
        n_pass  = 0;

        vecs[0] = '{32'd100,        32'd20,         32'd0,      1'b0, 32'd120,        1'b0, 1'b0, 1'b0, 32'd104};
        vecs[1] = '{32'd0,          32'd4,          32'd0,      1'b0, 32'd4,          1'b0, 1'b0, 1'b0, 32'd4};
        vecs[2] = '{32'd128,        32'hFFFF_FFF8,  32'd0,      1'b0, 32'd120,        1'b0, 1'b0, 1'b0, 32'd132};
        vecs[3] = '{32'hFFFF_FFFF,  32'd1,          32'd0,      1'b0, 32'd0,          1'b0, 1'b0, 1'b1, 32'd3};
        vecs[4] = '{32'd0,          32'hFFFF_FFFC,  32'd0,      1'b0, 32'hFFFF_FFFC,  1'b0, 1'b0, 1'b1, 32'd4};
        vecs[5] = '{32'h200,        32'd2,          32'h1003,   1'b1, 32'h1004,       1'b0, 1'b0, 1'b0, 32'h204};
        vecs[6] = '{32'h200,        32'd6,          32'h1000,   1'b1, 32'h1006,       1'b1, 1'b0, 1'b0, 32'h204};
        vecs[7] = '{32'h102,        32'd0,          32'h5,      1'b0, 32'h102,        1'b1, 1'b0, 1'b0, 32'h106};
        vecs[8] = '{32'd1,          32'd0,          32'h0,      1'b0, 32'd1,          1'b1, 1'b1, 1'b0, 32'd5};

        rst_n = 1'b0;
        drive('0, '0, '0, 1'b0, 1'b0);
        #12;
        chk32("reset target_q", if32.target_q, 32'd0);
        chk1("reset misaligned_q", if32.misaligned_q, 1'b0);
        chk1("reset wrap_q", if32.wrap_q, 1'b0);
        chk1("reset out_valid", if32.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, combinational outputs only (in_valid held low).
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].jalr, 1'b0);
            #1;
            chk32($sformatf("vec%0d target", i), if32.branch_target, vecs[i].exp_target);
            chk32($sformatf("vec%0d pc_plus4", i), if32.pc_plus4, vecs[i].exp_pc4);
            chk1($sformatf("vec%0d wrap", i), if32.wrap, vecs[i].exp_wrap);
            chk1($sformatf("vec%0d mis32", i), if32.misaligned, vecs[i].exp_mis32);
            chk1($sformatf("vec%0d mis16", i), if16.misaligned, vecs[i].exp_mis16);
        end
        @(posedge clk);
        #1;
        chk1("table out_valid low", if32.out_valid, 1'b0);
        chk32("table target_q untouched", if32.target_q, 32'd0);

        // Randomized stimulus against the reference, registered path included.
        hq32 = '0; hq16 = '0; hm32 = 1'b0; hm16 = 1'b0; hw = 1'b0; hv = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rp = $urandom;
            ri = $urandom;
            rr = $urandom;
            case ($urandom_range(0, 3))
                0: ri = $urandom_range(0, 64) - 32;
                1: rp = 32'hFFFF_FF00 | $urandom_range(0, 255);
                default: ;
            endcase
            rj = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            drive(rp, ri, rr, rj, rv);
            #1;
            model(rp, ri, rr, rj, et, em32, em16, ew, ep4);
            chk32("rand target", if32.branch_target, et);
            chk32("rand pc_plus4", if32.pc_plus4, ep4);
            chk1("rand wrap", if32.wrap, ew);
            chk1("rand mis32", if32.misaligned, em32);
            chk1("rand mis16", if16.misaligned, em16);
            hv = rv;
            if (rv) begin
                hq32 = et; hq16 = et; hm32 = em32; hm16 = em16; hw = ew;
            end
            @(posedge clk);
            #1;
            chk1("rand out_valid", if32.out_valid, hv);
            chk32("rand target_q", if32.target_q, hq32);
            chk1("rand misaligned_q32", if32.misaligned_q, hm32);
            chk1("rand misaligned_q16", if16.misaligned_q, hm16);
            chk1("rand wrap_q", if32.wrap_q, hw);
            chk32("rand target_q16", if16.target_q, hq16);
        end

        // Registered capture, hold, asynchronous reset, post-reset capture.
        @(negedge clk);
        drive(32'd100, 32'd20, 32'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk32("seq capture target_q", if32.target_q, 32'd120);
        chk1("seq capture out_valid", if32.out_valid, 1'b1);
        @(negedge clk);
        drive(32'h4000, 32'd8, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk32("seq hold target_q", if32.target_q, 32'd120);
        chk1("seq hold out_valid", if32.out_valid, 1'b0);
        @(negedge clk);
        drive(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk1("seq wrap_q", if32.wrap_q, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk32("async reset target_q", if32.target_q, 32'd0);
        chk1("async reset out_valid", if32.out_valid, 1'b0);
        chk1("async reset wrap_q", if32.wrap_q, 1'b0);
        chk32("comb live in reset", if32.branch_target, 32'd0);
        chk32("pc_plus4 live in reset", if32.pc_plus4, 32'd3);
        @(posedge clk);
        #1;
        chk1("reset discards capture", if32.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h1000, 32'd6, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk32("post-reset target_q", if32.target_q, 32'h1006);
        chk1("post-reset misaligned_q32", if32.misaligned_q, 1'b1);
        chk1("post-reset misaligned_q16", if16.misaligned_q, 1'b0);
        chk1("post-reset out_valid", if32.out_valid, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/branch_target_adder.md
Name: branch_target_adder

Overview:
Computes RISC-V control-transfer targets for the single-cycle core's fetch/PC-select path.
- Branch/JAL targets are pc + imm_gn.
- JALR targets are rs1 + imm_gn with bit 0 cleared.
- Also provides pc + 4, a target-misalignment flag and an address-wrap flag.
- All results are available combinationally, plus a registered copy with valid for pipelined or multi-cycle consumers.

Parameters:
XLEN, 32, datapath width of pc, rs1, imm_gn and all targets.
IALIGN, 32, instruction alignment in bits. 32 checks target[1:0]; 16 (C extension) checks target[0] only. Any other value is illegal.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
pc  input  XLEN  address of the current instruction.
imm_gn  input  XLEN  sign-extended immediate from the immediate generator, two's complement.
rs1  input  XLEN  register source 1 value, used only when is_jalr=1.
is_jalr  input  1  1 selects rs1 as base with LSB clear; 0 selects pc as base.
in_valid  input  1  current inputs are a real control transfer to capture.
branch_target  output  XLEN  combinational target.
pc_plus4  output  XLEN  combinational pc + 4, modulo 2^XLEN.
misaligned  output  1  combinational; target violates IALIGN.
wrap  output  1  combinational; target wrapped around the address space.
target_q  output  XLEN  registered branch_target.
misaligned_q  output  1  registered misaligned.
wrap_q  output  1  registered wrap.
out_valid  output  1  registered in_valid.

Behaviour:
- Clocking: one clock domain (clk). Asynchronous active-low reset (rst_n).
- Base selection: base = is_jalr ? rs1 : pc.
- Sum: sum = base + imm_gn, XLEN-bit modulo-2^XLEN addition. Carry-out c is kept internally.
- Target: branch_target = sum when is_jalr=0; {sum[XLEN-1:1],1'b0} when is_jalr=1.
- Signedness: imm_gn is treated as signed. No saturation; results wrap silently.
- wrap = c XOR imm_gn[XLEN-1]:
  - positive imm with carry-out wraps past all-ones to 0;
  - negative imm with no carry borrows below 0.
- misaligned:
  - IALIGN=32: branch_target[1:0] != 0.
  - IALIGN=16: branch_target[0] != 0, which is always 0 for JALR.
- pc_plus4 = pc + 4 modulo 2^XLEN, independent of is_jalr.
- Combinational outputs have zero latency, settle within the same cycle, and do not depend on clk, rst_n or in_valid.
- Registered path: on each rising clk edge with rst_n=1:
  - out_valid <= in_valid.
  - If in_valid=1: target_q, misaligned_q and wrap_q load their combinational counterparts.
  - If in_valid=0: they hold their previous values.
  - Latency is 1 cycle. There is no backpressure.
- Reset:
  - rst_n=0 immediately forces target_q=0, misaligned_q=0, wrap_q=0, out_valid=0, regardless of clk.
  - Reset asserted mid-operation discards the pending capture.
  - The first rising edge after deassertion behaves normally.
  - Combinational outputs stay live during reset.
- X-safety: in_valid=0 must never propagate unknown data into target_q.

Test Plan:
- pc=100, imm_gn=20, is_jalr=0 -> branch_target=120 (0x78), misaligned=0, wrap=0, pc_plus4=104.
- pc=0, imm_gn=4 -> branch_target=4, misaligned=0, wrap=0.
- pc=128, imm_gn=0xFFFFFFF8 (-8) -> branch_target=120, wrap=0 (carry with negative imm is not a wrap).
- pc=0xFFFFFFFF, imm_gn=1 -> branch_target=0, wrap=1, misaligned=0, pc_plus4=3. Also pc=0, imm_gn=-4 -> 0xFFFFFFFC, wrap=1.
- is_jalr=1, rs1=0x1003, imm_gn=2 -> branch_target=0x1004, misaligned=0. Then rs1=0x1000, imm_gn=6 -> 0x1006, misaligned=1 (IALIGN=32), misaligned=0 (IALIGN=16).
- Registered path:
  - in_valid=1 with pc=100, imm_gn=20 -> after 1 edge: target_q=120, out_valid=1.
  - in_valid=0 next cycle -> target_q holds 120, out_valid=0.
  - rst_n pulsed low between edges -> target_q=0 and out_valid=0 immediately.
